// File: rtl/tespar_frame_ctrl.sv
// TESPAR frame sequencer: gates the sample stream into the feature datapath,
// counts window/hop boundaries, waits out datapath latency, then snapshots
// the histogram and serialises it one bin per beat on a valid/ready stream.
module tespar_frame_ctrl #(
    parameter int unsigned WINDOW_SIZE = 256,
    parameter int unsigned HOP         = 64,
    parameter int unsigned ALPHA_COUNT = 8,
    parameter int unsigned PIPE_LAT    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [7:0]                s_data,
    output logic                      dp_en,
    output logic [7:0]                dp_data,
    output logic                      dp_clear,
    input  logic [ALPHA_COUNT*16-1:0] fv_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [3:0]                m_bin,
    output logic [15:0]               m_count,
    output logic                      m_last,
    output logic [15:0]               frame_cnt,
    output logic                      busy
);

    localparam int unsigned SW = $clog2(WINDOW_SIZE + 1);
    localparam int unsigned LW = $clog2(PIPE_LAT + 2);
    localparam int unsigned HW = ALPHA_COUNT * 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_SETTLE,
        S_DUMP,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   samp_q, samp_d;
    logic [LW-1:0]   settle_q, settle_d;
    logic [HW-1:0]   snap_q, snap_d;
    logic            m_valid_q, m_valid_d;
    logic [3:0]      m_bin_q, m_bin_d;
    logic [15:0]     m_count_q, m_count_d;
    logic            m_last_q, m_last_d;
    logic [15:0]     frame_q, frame_d;
    logic            stop_pend_q, stop_pend_d;
    logic            accept;

    // Select the 16-bit count of bin b (bins numbered from 1).
    function automatic logic [15:0] bin_of(input logic [HW-1:0] vec, input logic [3:0] b);
        int unsigned idx;
        idx = (32'(b) - 32'd1) * 32'd16;
        return vec[idx +: 16];
    endfunction

    // Stream-side strobes decode straight from state so s_ready never depends on s_valid.
    always_comb begin
        s_ready  = (state_q == S_FILL) || (state_q == S_RUN);
        accept   = s_valid & s_ready;
        dp_en    = accept;
        dp_data  = s_data;
        dp_clear = (state_q == S_CLEAR);
        busy     = (state_q != S_IDLE);
    end

    assign m_valid   = m_valid_q;
    assign m_bin     = m_bin_q;
    assign m_count   = m_count_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        settle_d    = settle_q;
        snap_d      = snap_q;
        m_valid_d   = m_valid_q;
        m_bin_d     = m_bin_q;
        m_count_d   = m_count_q;
        m_last_d    = m_last_q;
        frame_d     = frame_q;
        stop_pend_d = stop_pend_q;

        // A stop outside DUMP abandons the partial window immediately.
        if (stop && (state_q inside {S_CLEAR, S_FILL, S_SETTLE, S_RUN})) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    frame_d = '0;
                    samp_d  = '0;
                    state_d = S_FILL;
                end
                S_FILL, S_RUN: begin
                    if (accept) begin
                        if (samp_q == ((state_q == S_FILL) ? SW'(WINDOW_SIZE - 1) : SW'(HOP - 1))) begin
                            samp_d   = '0;
                            settle_d = '0;
                            state_d  = S_SETTLE;
                        end else begin
                            samp_d = samp_q + SW'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_q == LW'(PIPE_LAT)) begin
                        snap_d    = fv_in;
                        m_valid_d = 1'b1;
                        m_bin_d   = 4'd1;
                        m_count_d = fv_in[15:0];
                        m_last_d  = (ALPHA_COUNT == 1);
                        settle_d  = '0;
                        state_d   = S_DUMP;
                    end else begin
                        settle_d = settle_q + LW'(1);
                    end
                end
                S_DUMP: begin
                    if (stop) stop_pend_d = 1'b1;
                    if (m_valid_q && m_ready) begin
                        if (m_bin_q == 4'(ALPHA_COUNT)) begin
                            m_valid_d = 1'b0;
                            m_last_d  = 1'b0;
                            frame_d   = frame_q + 16'd1;
                            samp_d    = '0;
                            state_d   = (stop || stop_pend_q) ? S_IDLE : S_RUN;
                        end else begin
                            m_bin_d   = m_bin_q + 4'd1;
                            m_count_d = bin_of(snap_q, m_bin_q + 4'd1);
                            m_last_d  = ((m_bin_q + 4'd1) == 4'(ALPHA_COUNT));
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_IDLE) stop_pend_d = 1'b0;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            samp_q      <= '0;
            settle_q    <= '0;
            snap_q      <= '0;
            m_valid_q   <= 1'b0;
            m_bin_q     <= 4'd1;
            m_count_q   <= '0;
            m_last_q    <= 1'b0;
            frame_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            settle_q    <= settle_d;
            snap_q      <= snap_d;
            m_valid_q   <= m_valid_d;
            m_bin_q     <= m_bin_d;
            m_count_q   <= m_count_d;
            m_last_q    <= m_last_d;
            frame_q     <= frame_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule
